// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter.
// Takes one N-bit word per valid/ready handshake and shifts it out one bit
// per clock on sdo. sdo_valid/sdo_last frame the bits for a downstream
// deserializer. A word accepted in the last-bit cycle follows with no gap.
module piso_tx #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         sdo,
    output logic         sdo_valid,
    output logic         sdo_last,
    output logic         busy
);

    localparam int           CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic [N-1:0]  r_shreg,     w_shreg_nxt;
    logic [CW-1:0] r_cnt,       w_cnt_nxt;
    logic          r_din_ready, w_din_ready_nxt;
    logic          r_sdo_valid, w_sdo_valid_nxt;
    logic          r_sdo_last,  w_sdo_last_nxt;
    logic          w_accept;
    logic [N-1:0]  w_shifted;

    assign w_accept = din_valid & r_din_ready;

    // Move the word one position toward the output end, filling with zero.
    // Both slices are legal for every N >= 2.
    assign w_shifted = MSB_FIRST ? {r_shreg[N-2:0], 1'b0}
                                 : {1'b0, r_shreg[N-1:1]};

    // The output-end bit of the shift register is the serial output. It is a
    // flop output, and the register holds zero whenever idle, so sdo stays 0.
    assign sdo       = MSB_FIRST ? r_shreg[N-1] : r_shreg[0];
    assign sdo_valid = r_sdo_valid;
    assign sdo_last  = r_sdo_last;
    assign busy      = r_sdo_valid;
    assign din_ready = r_din_ready;

    // State, datapath and registered strobes. Reset clears them asynchronously,
    // so a frame in flight is aborted immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_din_ready <= 1'b0;
            r_sdo_valid <= 1'b0;
            r_sdo_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_din_ready <= w_din_ready_nxt;
            r_sdo_valid <= w_sdo_valid_nxt;
            r_sdo_last  <= w_sdo_last_nxt;
        end
    end

    // Next-state logic. The strobes and din_ready are computed from the next
    // state, so they line up with the bit that appears on sdo.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_shreg_nxt = din;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST) begin
                    if (w_accept) begin
                        // Back-to-back: the next word's first bit follows
                        // directly after this frame's last bit.
                        w_shreg_nxt = din;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_shreg_nxt = '0;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_shreg_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_shreg_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase

        w_sdo_valid_nxt = (w_state_nxt == SHIFT);
        w_sdo_last_nxt  = (w_state_nxt == SHIFT) && (w_cnt_nxt == LAST);
        // Ready while idle, and during the last bit so the next word can chain.
        w_din_ready_nxt = (w_state_nxt == IDLE) || w_sdo_last_nxt;
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed testbench for piso_tx. Two instances (MSB-first and LSB-first)
// share the stimulus. Outputs are sampled 1 ns after each rising edge.
module tb_piso_tx;

    logic       clk;
    logic       reset_n;
    logic [7:0] din;
    logic       din_valid;

    logic m_rdy, m_sdo, m_vld, m_last, m_busy;
    logic l_rdy, l_sdo, l_vld, l_last, l_busy;

    int n_tests = 0;
    int n_fail  = 0;

    piso_tx #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(m_rdy), .sdo(m_sdo), .sdo_valid(m_vld),
        .sdo_last(m_last), .busy(m_busy)
    );

    piso_tx #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(l_rdy), .sdo(l_sdo), .sdo_valid(l_vld),
        .sdo_last(l_last), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Outputs packed as {sdo, sdo_valid, sdo_last, busy, din_ready}
    function automatic logic [4:0] m_outs();
        return {m_sdo, m_vld, m_last, m_busy, m_rdy};
    endfunction
    function automatic logic [4:0] l_outs();
        return {l_sdo, l_vld, l_last, l_busy, l_rdy};
    endfunction

    // Send one word and check the 8-bit frame on the chosen instance.
    // seq[7] is the first bit expected on sdo.
    task automatic run_frame(input string tag, input logic [7:0] w,
                             input bit use_msb, input logic [7:0] seq);
        logic s, v, la, b, r;
        din       = w;
        din_valid = 1'b1;
        tick;                       // acceptance edge k
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {s, v, la, b, r} = use_msb ? m_outs() : l_outs();
            chk($sformatf("%s sdo[%0d]", tag, i), 32'(s), 32'(seq[7-i]));
            chk($sformatf("%s vld[%0d]", tag, i), 32'(v), 32'd1);
            chk($sformatf("%s busy[%0d]", tag, i), 32'(b), 32'd1);
            chk($sformatf("%s last[%0d]", tag, i), 32'(la), 32'(i == 7));
            chk($sformatf("%s rdy[%0d]", tag, i), 32'(r), 32'(i == 7));
            tick;
        end
        {s, v, la, b, r} = use_msb ? m_outs() : l_outs();
        chk({tag, " idle after"}, 32'({s, v, la, b, r}), 32'b00001);
    endtask

    initial begin
        logic [15:0] bb_seq;
        reset_n   = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;

        // Reset: all outputs held at 0, even across clock edges
        #12;
        chk("rst m_outs", 32'(m_outs()), 32'h0);
        chk("rst l_outs", 32'(l_outs()), 32'h0);
        #10;
        reset_n = 1'b1;            // released between edges
        #1;
        chk("rdy before edge", 32'(m_rdy), 32'd0);
        tick;
        chk("rdy after edge m", 32'(m_outs()), 32'b00001);
        chk("rdy after edge l", 32'(l_outs()), 32'b00001);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("idle stable %0d", i), 32'(m_outs()), 32'b00001);
        end

        // Single frames, both bit orders
        run_frame("msb A5", 8'hA5, 1'b1, 8'b1010_0101);
        run_frame("lsb A5", 8'hA5, 1'b0, 8'b1010_0101);
        run_frame("msb 01", 8'h01, 1'b1, 8'b0000_0001);
        run_frame("lsb 01", 8'h01, 1'b0, 8'b1000_0000);
        tick;

        // Back-to-back: F0 then 0F with din_valid held high
        bb_seq    = 16'b1111_0000_0000_1111;
        din       = 8'hF0;
        din_valid = 1'b1;
        tick;
        din = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) din_valid = 1'b0;
            chk($sformatf("b2b sdo[%0d]", i), 32'(m_sdo), 32'(bb_seq[15-i]));
            chk($sformatf("b2b vld[%0d]", i), 32'(m_vld), 32'd1);
            chk($sformatf("b2b last[%0d]", i), 32'(m_last), 32'(i == 7 || i == 15));
            tick;
        end
        chk("b2b idle after", 32'(m_outs()), 32'b00001);
        tick;

        // din changes mid-frame with din_valid low: frame unaffected
        din       = 8'h00;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) din = 8'hFF;
            chk($sformatf("mid sdo[%0d]", i), 32'(m_sdo), 32'd0);
            chk($sformatf("mid vld[%0d]", i), 32'(m_vld), 32'd1);
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid no-send %0d", i), 32'(m_outs()), 32'b00001);
            tick;
        end

        // Reset pulsed during bit 3 of FF: immediate clear, no residue
        din       = 8'hFF;
        din_valid = 1'b1;
        tick;
        din_valid = 1'b0;
        tick; tick; tick;          // now showing bit 3
        chk("pre-abort m_outs", 32'(m_outs()), 32'b11010);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort m_outs", 32'(m_outs()), 32'h0);
        chk("abort l_outs", 32'(l_outs()), 32'h0);
        #3;
        reset_n = 1'b1;
        #1;
        chk("abort rdy before edge", 32'(m_rdy), 32'd0);
        tick;
        chk("abort rdy after edge", 32'(m_outs()), 32'b00001);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk($sformatf("abort no residue m %0d", i), 32'(m_outs()), 32'b00001);
            chk($sformatf("abort no residue l %0d", i), 32'(l_outs()), 32'b00001);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter: the feeding end of the team's serial data path.
- Accepts one N-bit word per valid/ready handshake and shifts it out one bit per clock on sdo.
- Frame strobes mark valid bits and the last bit, so a downstream shift-register receiver or deserializer can capture the word.
- Supports back-to-back words with zero idle cycles between frames.

Parameters:
- N, 8: word width in bits; legal range N >= 2.
- MSB_FIRST, 1: 1 = transmit din[N-1] first; 0 = transmit din[0] first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- din  input  N  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  transmitter accepts din on this cycle.
- sdo  output  1  serial data out (registered).
- sdo_valid  output  1  sdo carries a frame bit this cycle (registered).
- sdo_last  output  1  sdo carries the final bit of the frame (registered).
- busy  output  1  a frame is in progress (equals sdo_valid).

Behaviour:
- Reset is asynchronous and active-low on reset_n; clk is the single clock.
- While reset_n = 0, all outputs are 0:
  - sdo = 0, sdo_valid = 0, sdo_last = 0, busy = 0, din_ready = 0.
  - State = IDLE, shift register = 0, bit counter = 0.
- din_ready is registered. It rises on the first rising edge after reset_n deasserts.
- Handshake: a word is accepted on a rising edge where din_valid = 1 and din_ready = 1.
  - din is ignored at all other times.
  - din_valid may stay high across cycles with no effect until accepted.
- FSM has two states, IDLE and SHIFT.
  - IDLE: sdo = 0, sdo_valid = 0, din_ready = 1. On acceptance, load the shift register from din, set counter = 0, go to SHIFT.
  - SHIFT: sdo_valid = 1 and sdo = current output bit. The counter increments each cycle from 0 to N-1. The shift register moves one position toward the output end and fills with 0.
  - MSB_FIRST = 1: output end is bit N-1, shift left. MSB_FIRST = 0: output end is bit 0, shift right.
- Latency: if accepted at edge k, bit i of the frame (i = 0..N-1, in transmit order) is on sdo in the cycle after edge k+i. sdo_valid is high for exactly N consecutive cycles.
- sdo_last = 1 only in the cycle where counter = N-1.
- din_ready in SHIFT:
  - din_ready = 1 during the sdo_last cycle, 0 in all other SHIFT cycles.
  - If accepted in the sdo_last cycle: reload, counter = 0, stay in SHIFT. Bit 0 of the new word follows the old last bit with no gap, so sdo_valid stays continuously high.
  - If not accepted in the sdo_last cycle: go to IDLE. sdo_valid and sdo fall to 0 on the next edge.
- Counter width is $clog2(N). Counter wrap never occurs; the counter is reloaded to 0 or the FSM exits at N-1.
- din changing mid-frame has no effect on the frame in flight.
- Reset asserted mid-frame aborts the frame immediately (asynchronous clear); no partial bits resume after release.
- When idle, outputs are stable with no toggling on sdo.

Test Plan:
- Reset release, din_valid = 0 → all outputs 0 during reset; din_ready = 1 one edge after release; sdo = 0 and sdo_valid = 0 indefinitely.
- N = 8, MSB_FIRST = 1, din = 8'hA5 accepted at edge k → sdo = 1,0,1,0,0,1,0,1 on cycles k+1..k+8; sdo_valid high for those 8 cycles; sdo_last high only on cycle k+8; din_ready low on k+1..k+7 and high on k+8.
- MSB_FIRST = 0, din = 8'hA5 → sdo = 1,0,1,0,0,1,0,1 (LSB first); same timing as the MSB-first case.
- Back-to-back: din_valid held high with 8'hF0 then 8'h0F → 16 consecutive cycles with sdo_valid = 1; sdo = 1111000000001111; sdo_last pulses on cycles 8 and 16; returns to IDLE after cycle 16.
- din changed to 8'hFF in mid-frame of 8'h00, with din_valid = 0 → sdo stays 0 for all 8 bits; the new din is not transmitted.
- reset_n pulsed low during bit 3 of 8'hFF → sdo, sdo_valid, sdo_last, busy, din_ready = 0 immediately without waiting for a clock edge; after release, din_ready = 1 after one edge, and no residual bits appear.
